// File: rtl/cache_writeback_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_writeback_unit_if
//  Brief    : AXI-style write channel bundle (AW, W, B) between the
//             write-back unit (master) and the memory bus (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface cache_writeback_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  // Address channel
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  // Data channel
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  // Response channel
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    output awready, wready, bvalid, bresp
  );
endinterface
`default_nettype wire

// File: rtl/cache_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cache_writeback_unit
//  Brief    : Drains one dirty direct-mapped cache line to memory as a single
//             INCR write burst: one address phase, 2^(LINE_WIDTH-2) data
//             beats read from the line's word-index port, one response.
//  Options  : CACHE_WB_ERR_EN - when defined, a non-OKAY write response sets
//             the sticky wb_err flag; otherwise wb_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_writeback_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 6,
  parameter int CACHE_WIDTH = 6
) (
  input  wire                                       clk,
  input  wire                                       rst,
  input  wire                                       wb_req,
  input  wire [ADDR_WIDTH-LINE_WIDTH-CACHE_WIDTH-1:0] wb_tag,
  input  wire [CACHE_WIDTH-1:0]                     wb_set,
  output logic                                      wb_busy,
  output logic                                      wb_done,
  output logic                                      wb_err,
  output logic [LINE_WIDTH-3:0]                     line_index,
  input  wire [31:0]                                line_data,
  cache_writeback_unit_if.master                    bus
);

  localparam int IDX_WIDTH = LINE_WIDTH - 2;
  localparam int NW        = 1 << IDX_WIDTH;

  // Counter is one bit wider than the word index so it can reach NW.
  localparam logic [IDX_WIDTH:0] C_CNT_ONE  = (IDX_WIDTH + 1)'(1);
  localparam logic [IDX_WIDTH:0] C_CNT_LAST = (IDX_WIDTH + 1)'(NW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                  r_state,   w_state_nxt;
  logic                    r_awvalid, w_awvalid_nxt;
  logic [ADDR_WIDTH-1:0]   r_awaddr,  w_awaddr_nxt;
  logic                    r_wvalid,  w_wvalid_nxt;
  logic [31:0]             r_wdata,   w_wdata_nxt;
  logic                    r_wlast,   w_wlast_nxt;
  logic                    r_bready,  w_bready_nxt;
  logic                    r_done,    w_done_nxt;
  logic [IDX_WIDTH:0]      r_cnt,     w_cnt_nxt;
  logic [IDX_WIDTH-1:0]    w_line_index;
`ifdef CACHE_WB_ERR_EN
  logic                    r_err,     w_err_nxt;
`endif

  // State and datapath registers; reset drops every valid immediately.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
      r_wvalid  <= 1'b0;
      r_wdata   <= '0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
`ifdef CACHE_WB_ERR_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wlast   <= w_wlast_nxt;
      r_bready  <= w_bready_nxt;
      r_done    <= w_done_nxt;
      r_cnt     <= w_cnt_nxt;
`ifdef CACHE_WB_ERR_EN
      r_err     <= w_err_nxt;
`endif
    end
  end

  // Next-state logic: sequence address, data beats and response per request.
  always_comb begin
    w_state_nxt   = r_state;
    w_awvalid_nxt = r_awvalid;
    w_awaddr_nxt  = r_awaddr;
    w_wvalid_nxt  = r_wvalid;
    w_wdata_nxt   = r_wdata;
    w_wlast_nxt   = r_wlast;
    w_bready_nxt  = r_bready;
    w_done_nxt    = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_line_index  = '0;
`ifdef CACHE_WB_ERR_EN
    w_err_nxt     = r_err;
`endif

    case (r_state)
      S_IDLE: begin
        // Requests arriving while busy never reach here, so they are dropped.
        if (wb_req) begin
          w_awaddr_nxt  = {wb_tag, wb_set, {LINE_WIDTH{1'b0}}};
          w_awvalid_nxt = 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_ADDR;
        end
      end

      S_ADDR: begin
        // Word 0 is pre-fetched so the first beat is ready right after AW.
        w_line_index = '0;
        if (r_awvalid && bus.awready) begin
          w_awvalid_nxt = 1'b0;
          w_wdata_nxt   = line_data;
          w_cnt_nxt     = C_CNT_ONE;
          w_wvalid_nxt  = 1'b1;
          w_wlast_nxt   = (NW == 1);
          w_state_nxt   = S_DATA;
        end
      end

      S_DATA: begin
        // The counter always points at the word to load for the next beat.
        w_line_index = r_cnt[IDX_WIDTH-1:0];
        if (r_wvalid && bus.wready) begin
          if (r_wlast) begin
            w_wvalid_nxt = 1'b0;
            w_wlast_nxt  = 1'b0;
            w_bready_nxt = 1'b1;
            w_state_nxt  = S_RESP;
          end else begin
            w_wdata_nxt = line_data;
            w_cnt_nxt   = r_cnt + C_CNT_ONE;
            w_wlast_nxt = (r_cnt == C_CNT_LAST);
          end
        end
      end

      S_RESP: begin
        if (r_bready && bus.bvalid) begin
          w_bready_nxt = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_IDLE;
`ifdef CACHE_WB_ERR_EN
          if (bus.bresp != 2'b00) begin
            w_err_nxt = 1'b1;
          end
`endif
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.awvalid = r_awvalid;
  assign bus.awaddr  = r_awaddr;
  assign bus.awlen   = 8'(NW - 1);
  assign bus.awsize  = 3'b010;
  assign bus.awburst = 2'b01;
  assign bus.wvalid  = r_wvalid;
  assign bus.wdata   = r_wdata;
  assign bus.wstrb   = 4'hF;
  assign bus.wlast   = r_wlast;
  assign bus.bready  = r_bready;

  assign wb_busy    = (r_state != S_IDLE);
  assign wb_done    = r_done;
  assign line_index = w_line_index;

`ifdef CACHE_WB_ERR_EN
  assign wb_err = r_err;
`else
  // Response code carries no meaning when error reporting is disabled.
  logic w_unused_bresp;
  assign w_unused_bresp = ^bus.bresp;
  assign wb_err         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_writeback_unit
//  Brief    : Self-checking bench for cache_writeback_unit. Expected beats are
//             queued when a request is issued and popped as beats complete.
//  Options  : CACHE_WB_ERR_EN selects the expected wb_err behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_writeback_unit;

  localparam int NW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_req = 1'b0;
  logic [19:0] wb_tag = '0;
  logic [5:0]  wb_set = '0;
  logic        wb_busy, wb_done, wb_err;
  logic [3:0]  line_index;
  logic [31:0] line_data;
  logic [31:0] line_mem [NW];

  int checks   = 0;
  int errors   = 0;
  int beat_cnt = 0;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  assign line_data = line_mem[line_index];

  cache_writeback_unit_if #(.ADDR_WIDTH(32)) bus ();

  cache_writeback_unit #(
    .ADDR_WIDTH (32),
    .LINE_WIDTH (6),
    .CACHE_WIDTH(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_req    (wb_req),
    .wb_tag    (wb_tag),
    .wb_set    (wb_set),
    .wb_busy   (wb_busy),
    .wb_done   (wb_done),
    .wb_err    (wb_err),
    .line_index(line_index),
    .line_data (line_data),
    .bus       (bus.master)
  );

  // Beat monitor: samples mid-cycle, pops the scoreboard on each accepted beat
  // and checks that stalled channels hold their payload.
  initial begin
    logic        prev_wstall  = 1'b0;
    logic        prev_awstall = 1'b0;
    logic [31:0] prev_wdata   = '0;
    logic        prev_wlast   = 1'b0;
    logic [31:0] prev_awaddr  = '0;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        prev_wstall  = 1'b0;
        prev_awstall = 1'b0;
      end else begin
        if (prev_awstall) begin
          checks++;
          if (bus.awvalid !== 1'b1 || bus.awaddr !== prev_awaddr) begin
            errors++;
            $display("FAIL aw_hold: awvalid=%b awaddr=%h required awvalid=1 awaddr=%h",
                     bus.awvalid, bus.awaddr, prev_awaddr);
          end
        end
        if (prev_wstall) begin
          checks++;
          if (bus.wvalid !== 1'b1 || bus.wdata !== prev_wdata || bus.wlast !== prev_wlast) begin
            errors++;
            $display("FAIL w_hold: wvalid=%b wdata=%h wlast=%b required wvalid=1 wdata=%h wlast=%b",
                     bus.wvalid, bus.wdata, bus.wlast, prev_wdata, prev_wlast);
          end
        end
        if (bus.wvalid === 1'b1 && bus.wready === 1'b1) begin
          beat_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: wdata=%h wlast=%b required no beat", bus.wdata, bus.wlast);
          end else begin
            e = exp_q.pop_front();
            if ({bus.wlast, bus.wdata} !== e) begin
              errors++;
              $display("FAIL beat_data: wlast=%b wdata=%h required wlast=%b wdata=%h",
                       bus.wlast, bus.wdata, e[32], e[31:0]);
            end
          end
        end
        prev_awstall = (bus.awvalid === 1'b1) && (bus.awready !== 1'b1);
        prev_awaddr  = bus.awaddr;
        prev_wstall  = (bus.wvalid === 1'b1) && (bus.wready !== 1'b1);
        prev_wdata   = bus.wdata;
        prev_wlast   = bus.wlast;
      end
    end
  end

  // Loads a fresh line, queues its expected beats, issues a request and runs
  // until wb_done (mode 0 plain, 1 awready low 5 cycles, 2 wready toggling,
  // 3 extra wb_req pulse mid-burst). Returns with cycle k of wb_done sampled.
  task automatic run_burst(input logic [19:0] tag, input logic [5:0] set, input int mode,
                           output int done_k, output int aw_k, output int busy_gaps,
                           output logic [31:0] aw_addr_seen, output int early_w);
    done_k = -1; aw_k = -1; busy_gaps = 0; early_w = 0; aw_addr_seen = '0;
    for (int i = 0; i < NW; i++) line_mem[i] = $urandom;
    for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW - 1), line_mem[i]});
    @(posedge clk); #1;
    wb_req = 1'b1; wb_tag = tag; wb_set = set;
    bus.awready = (mode != 1);
    bus.wready  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.wvalid === 1'b1 && aw_k < 0) early_w++;
      if (bus.awvalid === 1'b1 && bus.awready === 1'b1 && aw_k < 0) begin
        aw_k = k; aw_addr_seen = bus.awaddr;
      end
      if (wb_done === 1'b1) begin
        done_k = k;
        break;
      end
      if (k >= 1 && wb_busy !== 1'b1) busy_gaps++;
      @(posedge clk); #1;
      wb_req = (mode == 3 && k == 5);
      if (mode == 3) wb_tag = 20'h12345;
      if (mode == 1) bus.awready = (k >= 5);
      if (mode == 2) bus.wready = ~bus.wready;
    end
    bus.awready = 1'b1; bus.wready = 1'b1; wb_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wb_req = 1'b0;
    bus.awready = 1'b1; bus.wready = 1'b1; bus.bvalid = 1'b1; bus.bresp = 2'b00;
    for (int i = 0; i < NW; i++) line_mem[i] = 32'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.awvalid !== 1'b0) begin errors++; $display("FAIL rst_awvalid: got %b want 0", bus.awvalid); end
    checks++; if (bus.wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid: got %b want 0", bus.wvalid); end
    checks++; if (bus.wlast !== 1'b0) begin errors++; $display("FAIL rst_wlast: got %b want 0", bus.wlast); end
    checks++; if (bus.bready !== 1'b0) begin errors++; $display("FAIL rst_bready: got %b want 0", bus.bready); end
    checks++; if (wb_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", wb_done); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", wb_err); end
    checks++; if (wb_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", wb_busy); end
    checks++; if (bus.wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", bus.wdata); end
    checks++; if (bus.awaddr !== 32'h0) begin errors++; $display("FAIL rst_awaddr: got %h want 0", bus.awaddr); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int done_k, aw_k, gaps, early, b0;
    logic [31:0] a;
    b0 = beat_cnt;
    run_burst(20'hABCDE, 6'h05, 0, done_k, aw_k, gaps, a, early);
    checks++; if (aw_k != 1) begin errors++; $display("FAIL basic_aw_cycle: got %0d want 1", aw_k); end
    checks++; if (a !== 32'hABCDE140) begin errors++; $display("FAIL basic_awaddr: got %h want abcde140", a); end
    checks++; if (bus.awlen !== 8'd15) begin errors++; $display("FAIL basic_awlen: got %0d want 15", bus.awlen); end
    checks++; if (bus.awsize !== 3'b010 || bus.awburst !== 2'b01 || bus.wstrb !== 4'hF) begin
      errors++; $display("FAIL basic_consts: awsize=%b awburst=%b wstrb=%h want 010 01 f", bus.awsize, bus.awburst, bus.wstrb);
    end
    checks++; if (beat_cnt - b0 != NW) begin errors++; $display("FAIL basic_beats: got %0d want 16", beat_cnt - b0); end
    checks++; if (done_k != 19) begin errors++; $display("FAIL basic_done_cycle: got %0d want 19", done_k); end
    checks++; if (early != 0 || gaps != 0) begin errors++; $display("FAIL basic_proto: early_w=%0d busy_gaps=%0d want 0 0", early, gaps); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left: got %0d want 0", exp_q.size()); end
    @(negedge clk);
    checks++; if (wb_done !== 1'b0 || wb_busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: wb_done=%b wb_busy=%b want 0 0", wb_done, wb_busy);
    end
  endtask

  task automatic test_aw_stall();
    int done_k, aw_k, gaps, early, b0;
    logic [31:0] a;
    b0 = beat_cnt;
    run_burst(20'h0F0F0, 6'h3F, 1, done_k, aw_k, gaps, a, early);
    checks++; if (aw_k != 6) begin errors++; $display("FAIL awstall_aw_cycle: got %0d want 6", aw_k); end
    checks++; if (a !== 32'h0F0F0FC0) begin errors++; $display("FAIL awstall_awaddr: got %h want 0f0f0fc0", a); end
    checks++; if (early != 0) begin errors++; $display("FAIL awstall_early_w: got %0d want 0", early); end
    checks++; if (beat_cnt - b0 != NW) begin errors++; $display("FAIL awstall_beats: got %0d want 16", beat_cnt - b0); end
    checks++; if (done_k != 24) begin errors++; $display("FAIL awstall_done_cycle: got %0d want 24", done_k); end
  endtask

  task automatic test_w_stall();
    int done_k, aw_k, gaps, early, b0;
    logic [31:0] a;
    b0 = beat_cnt;
    run_burst(20'h55AA5, 6'h2A, 2, done_k, aw_k, gaps, a, early);
    checks++; if (beat_cnt - b0 != NW) begin errors++; $display("FAIL wstall_beats: got %0d want 16", beat_cnt - b0); end
    checks++; if (done_k < 0) begin errors++; $display("FAIL wstall_timeout: got done_k=%0d want completion", done_k); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wstall_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_req_during_busy();
    int done_k, aw_k, gaps, early, b0, extra;
    logic [31:0] a;
    b0 = beat_cnt; extra = 0;
    run_burst(20'h13579, 6'h11, 3, done_k, aw_k, gaps, a, early);
    checks++; if (gaps != 0) begin errors++; $display("FAIL busy_gap: got %0d gaps want 0", gaps); end
    checks++; if (done_k != 19) begin errors++; $display("FAIL busy_done_cycle: got %0d want 19", done_k); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wb_busy !== 1'b0 || bus.awvalid !== 1'b0) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL busy_requeued: got %0d busy cycles want 0", extra); end
    checks++; if (beat_cnt - b0 != NW) begin errors++; $display("FAIL busy_beats: got %0d want 16", beat_cnt - b0); end
  endtask

  task automatic test_midburst_reset();
    int done_k, aw_k, gaps, early, b0, k;
    logic [31:0] a;
    b0 = beat_cnt;
    for (int i = 0; i < NW; i++) line_mem[i] = $urandom;
    for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW - 1), line_mem[i]});
    @(posedge clk); #1;
    wb_req = 1'b1; wb_tag = 20'hCAFE1; wb_set = 6'h07;
    k = 0;
    while (beat_cnt - b0 < 7 && k < 100) begin
      @(posedge clk); #1;
      wb_req = 1'b0; k++;
    end
    checks++; if (beat_cnt - b0 != 7) begin errors++; $display("FAIL mrst_reach7: got %0d beats want 7", beat_cnt - b0); end
    rst = 1'b0; bus.wready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b0 || bus.bready !== 1'b0 || wb_busy !== 1'b0) begin
      errors++; $display("FAIL mrst_drop: awvalid=%b wvalid=%b bready=%b wb_busy=%b want 0 0 0 0",
                         bus.awvalid, bus.wvalid, bus.bready, wb_busy);
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b1; bus.wready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (beat_cnt - b0 != 7 || wb_busy !== 1'b0) begin
      errors++; $display("FAIL mrst_no_more: beats=%0d wb_busy=%b want 7 0", beat_cnt - b0, wb_busy);
    end
    b0 = beat_cnt;
    run_burst(20'h2468A, 6'h01, 0, done_k, aw_k, gaps, a, early);
    checks++; if (done_k != 19 || beat_cnt - b0 != NW) begin
      errors++; $display("FAIL mrst_restart: done_k=%0d beats=%0d want 19 16", done_k, beat_cnt - b0);
    end
  endtask

  task automatic test_err();
    int done_k, aw_k, gaps, early;
    logic [31:0] a;
    logic exp_err;
`ifdef CACHE_WB_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    bus.bresp = 2'b10;
    run_burst(20'h00001, 6'h02, 0, done_k, aw_k, gaps, a, early);
    checks++; if (done_k != 19) begin errors++; $display("FAIL err_done: got %0d want 19", done_k); end
    checks++; if (wb_err !== exp_err) begin errors++; $display("FAIL err_set: got %b want %b", wb_err, exp_err); end
    bus.bresp = 2'b00;
    run_burst(20'h00002, 6'h03, 0, done_k, aw_k, gaps, a, early);
    checks++; if (done_k != 19) begin errors++; $display("FAIL err_okay_done: got %0d want 19", done_k); end
    checks++; if (wb_err !== exp_err) begin errors++; $display("FAIL err_sticky: got %b want %b", wb_err, exp_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_stall();
    test_w_stall();
    test_req_during_busy();
    test_midburst_reset();
    test_err();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
